// File: rtl/rvfi_monitor.sv
// RVFI retirement-stream monitor: checks ordering, PC continuity, x0 and
// register read-back against a shadow register file, and latches the first violation.
module rvfi_monitor #(
    parameter int XLEN       = 32,
    parameter int IALIGN     = 32,
    parameter int CHECK_REGS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rvfi_valid,
    input  logic [63:0]     rvfi_order,
    input  logic [31:0]     rvfi_insn,
    input  logic            rvfi_trap,
    input  logic            rvfi_halt,
    input  logic [4:0]      rvfi_rs1_addr,
    input  logic [4:0]      rvfi_rs2_addr,
    input  logic [XLEN-1:0] rvfi_rs1_rdata,
    input  logic [XLEN-1:0] rvfi_rs2_rdata,
    input  logic [4:0]      rvfi_rd_addr,
    input  logic [XLEN-1:0] rvfi_rd_wdata,
    input  logic [XLEN-1:0] rvfi_pc_rdata,
    input  logic [XLEN-1:0] rvfi_pc_wdata,
    output logic            err,
    output logic [2:0]      err_code,
    output logic [63:0]     err_order,
    output logic [31:0]     err_insn,
    output logic [31:0]     retired,
    output logic            halted,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_WAIT_FIRST = 2'd0,
        S_RUN        = 2'd1,
        S_HALTED     = 2'd2,
        S_FAIL       = 2'd3
    } state_e;

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_ORDER = 3'd1;
    localparam logic [2:0] C_PC    = 3'd2;
    localparam logic [2:0] C_X0    = 3'd3;
    localparam logic [2:0] C_RS1   = 3'd4;
    localparam logic [2:0] C_RS2   = 3'd5;
    localparam logic [2:0] C_ALIGN = 3'd6;
    localparam logic [2:0] C_HALT  = 3'd7;

    state_e            state_q, state_d;
    logic [63:0]       exp_order_q, exp_order_d;
    logic [XLEN-1:0]   prev_pc_q, prev_pc_d;
    logic              pc_chk_q, pc_chk_d;
    logic              err_q, err_d;
    logic [2:0]        err_code_q, err_code_d;
    logic [63:0]       err_order_q, err_order_d;
    logic [31:0]       err_insn_q, err_insn_d;
    logic [31:0]       retired_q, retired_d;
    logic              halted_q, halted_d;
    logic [31:0]       shadow_vld_q, shadow_vld_d;
    logic [XLEN-1:0]   shadow_q [32];
    logic              shadow_we;

    logic              bad_order;
    logic              bad_pc;
    logic              bad_x0;
    logic              bad_rs1;
    logic              bad_rs2;
    logic              bad_align;
    logic [2:0]        beat_code;

    // Index 0 must read as zero; other registers are only checked once written.
    function automatic logic reg_mismatch(input logic [4:0] addr, input logic [XLEN-1:0] data);
        logic mismatch;
        if (addr == 5'd0) begin
            mismatch = (data != '0);
        end else begin
            mismatch = shadow_vld_q[addr] && (shadow_q[addr] != data);
        end
        return mismatch;
    endfunction

    always_comb begin
        bad_order = (rvfi_order != exp_order_q);
        bad_pc    = (state_q == S_RUN) && pc_chk_q && (rvfi_pc_rdata != prev_pc_q);
        bad_x0    = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
        bad_rs1   = 1'b0;
        bad_rs2   = 1'b0;
        if (CHECK_REGS != 0) begin
            bad_rs1 = reg_mismatch(rvfi_rs1_addr, rvfi_rs1_rdata);
            bad_rs2 = reg_mismatch(rvfi_rs2_addr, rvfi_rs2_rdata);
        end
        if (IALIGN == 16) begin
            bad_align = !rvfi_trap && rvfi_pc_wdata[0];
        end else begin
            bad_align = !rvfi_trap && (rvfi_pc_wdata[1:0] != 2'b00);
        end

        beat_code = C_NONE;
        if (bad_order) begin
            beat_code = C_ORDER;
        end else if (bad_pc) begin
            beat_code = C_PC;
        end else if (bad_x0) begin
            beat_code = C_X0;
        end else if (bad_rs1) begin
            beat_code = C_RS1;
        end else if (bad_rs2) begin
            beat_code = C_RS2;
        end else if (bad_align) begin
            beat_code = C_ALIGN;
        end
    end

    always_comb begin
        state_d      = state_q;
        exp_order_d  = exp_order_q;
        prev_pc_d    = prev_pc_q;
        pc_chk_d     = pc_chk_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        err_order_d  = err_order_q;
        err_insn_d   = err_insn_q;
        retired_d    = retired_q;
        halted_d     = halted_q;
        shadow_vld_d = shadow_vld_q;
        shadow_we    = 1'b0;

        case (state_q)
            S_WAIT_FIRST, S_RUN: begin
                if (rvfi_valid) begin
                    if (beat_code != C_NONE) begin
                        state_d     = S_FAIL;
                        err_d       = 1'b1;
                        err_code_d  = beat_code;
                        err_order_d = rvfi_order;
                        err_insn_d  = rvfi_insn;
                    end else begin
                        exp_order_d = rvfi_order + 64'd1;
                        prev_pc_d   = rvfi_pc_wdata;
                        // A trap redirects the PC, so the next beat's pc_rdata is not checked.
                        pc_chk_d    = !rvfi_trap;
                        if (retired_q != 32'hFFFF_FFFF) begin
                            retired_d = retired_q + 32'd1;
                        end
                        if ((rvfi_rd_addr != 5'd0) && !rvfi_trap) begin
                            shadow_we                  = 1'b1;
                            shadow_vld_d[rvfi_rd_addr] = 1'b1;
                        end
                        if (rvfi_halt) begin
                            halted_d = 1'b1;
                            state_d  = S_HALTED;
                        end else begin
                            state_d  = S_RUN;
                        end
                    end
                end
            end
            S_HALTED: begin
                if (rvfi_valid) begin
                    state_d     = S_FAIL;
                    err_d       = 1'b1;
                    err_code_d  = C_HALT;
                    err_order_d = rvfi_order;
                    err_insn_d  = rvfi_insn;
                end
            end
            default: begin
                state_d = S_FAIL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_WAIT_FIRST;
            exp_order_q  <= 64'd0;
            prev_pc_q    <= '0;
            pc_chk_q     <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= C_NONE;
            err_order_q  <= 64'd0;
            err_insn_q   <= 32'd0;
            retired_q    <= 32'd0;
            halted_q     <= 1'b0;
            shadow_vld_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            exp_order_q  <= exp_order_d;
            prev_pc_q    <= prev_pc_d;
            pc_chk_q     <= pc_chk_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_order_q  <= err_order_d;
            err_insn_q   <= err_insn_d;
            retired_q    <= retired_d;
            halted_q     <= halted_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end

    // Shadow data needs no reset: the valid bits gate every read.
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_q[rvfi_rd_addr] <= rvfi_rd_wdata;
        end
    end

    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_order = err_order_q;
    assign err_insn  = err_insn_q;
    assign retired   = retired_q;
    assign halted    = halted_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rvfi_monitor.sv
// Bench for rvfi_monitor: directed vector table plus randomized beats checked
// against a rule-level reference model.
module tb_rvfi_monitor;

    typedef struct {
        logic [63:0] order;
        logic [31:0] insn;
        logic [31:0] pcr;
        logic [31:0] pcw;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  rs1;
        logic [31:0] r1d;
        logic [4:0]  rs2;
        logic [31:0] r2d;
        logic        trap;
        logic        halt;
    } beat_t;

    typedef struct {
        bit          rst_first;
        beat_t       b;
        logic        e_err;
        logic [2:0]  e_code;
        logic [63:0] e_order;
        logic [31:0] e_ret;
        logic        e_halted;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rvfi_valid = 1'b0;
    logic [63:0] rvfi_order = '0;
    logic [31:0] rvfi_insn = '0;
    logic        rvfi_trap = 1'b0;
    logic        rvfi_halt = 1'b0;
    logic [4:0]  rvfi_rs1_addr = '0;
    logic [4:0]  rvfi_rs2_addr = '0;
    logic [31:0] rvfi_rs1_rdata = '0;
    logic [31:0] rvfi_rs2_rdata = '0;
    logic [4:0]  rvfi_rd_addr = '0;
    logic [31:0] rvfi_rd_wdata = '0;
    logic [31:0] rvfi_pc_rdata = '0;
    logic [31:0] rvfi_pc_wdata = '0;
    logic        err;
    logic [2:0]  err_code;
    logic [63:0] err_order;
    logic [31:0] err_insn;
    logic [31:0] retired;
    logic        halted;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    rvfi_monitor #(.XLEN(32), .IALIGN(32), .CHECK_REGS(1)) dut (
        .clk(clk), .rst(rst), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .err(err), .err_code(err_code), .err_order(err_order), .err_insn(err_insn),
        .retired(retired), .halted(halted), .dbg_state(dbg_state)
    );

    // reference model state
    bit          m_err;
    logic [2:0]  m_code;
    logic [63:0] m_eorder;
    logic [31:0] m_einsn;
    logic [31:0] m_ret;
    bit          m_halted;
    bit          m_after_trap;
    logic [31:0] m_last_pcw;
    logic [31:0] m_reg [32];
    bit          m_wr [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_err = 0; m_code = 0; m_eorder = 0; m_einsn = 0; m_ret = 0;
        m_halted = 0; m_after_trap = 0; m_last_pcw = 0;
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 0;
            m_wr[i] = 0;
        end
    endfunction

    function automatic bit model_reg_ok(input logic [4:0] a, input logic [31:0] d);
        if (a == 0) return d == 0;
        if (!m_wr[a]) return 1;
        return m_reg[a] == d;
    endfunction

    // Collect every violated rule, then report the smallest code.
    function automatic logic [2:0] model_code(input beat_t b);
        int codes[$];
        if (m_halted) return 3'd7;
        if (b.order != {32'd0, m_ret}) codes.push_back(1);
        if (m_ret != 0 && !m_after_trap && b.pcr != m_last_pcw) codes.push_back(2);
        if (b.rd == 0 && b.wd != 0) codes.push_back(3);
        if (!model_reg_ok(b.rs1, b.r1d)) codes.push_back(4);
        if (!model_reg_ok(b.rs2, b.r2d)) codes.push_back(5);
        if (!b.trap && b.pcw[1:0] != 2'b00) codes.push_back(6);
        if (codes.size() == 0) return 3'd0;
        codes.sort();
        return 3'(codes[0]);
    endfunction

    function automatic void model_apply(input beat_t b, input bit vld);
        logic [2:0] c;
        if (!vld || m_err) return;
        c = model_code(b);
        if (c != 0) begin
            m_err = 1; m_code = c; m_eorder = b.order; m_einsn = b.insn;
        end else begin
            if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
            m_last_pcw = b.pcw;
            m_after_trap = b.trap;
            if (b.rd != 0 && !b.trap) begin
                m_reg[b.rd] = b.wd;
                m_wr[b.rd] = 1;
            end
            if (b.halt) m_halted = 1;
        end
    endfunction

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        rvfi_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic drive_beat(input beat_t b, input bit vld);
        @(negedge clk);
        rvfi_valid = vld;
        rvfi_order = b.order;     rvfi_insn = b.insn;
        rvfi_pc_rdata = b.pcr;    rvfi_pc_wdata = b.pcw;
        rvfi_rd_addr = b.rd;      rvfi_rd_wdata = b.wd;
        rvfi_rs1_addr = b.rs1;    rvfi_rs1_rdata = b.r1d;
        rvfi_rs2_addr = b.rs2;    rvfi_rs2_rdata = b.r2d;
        rvfi_trap = b.trap;       rvfi_halt = b.halt;
        @(posedge clk);
        #1;
        model_apply(b, vld);
    endtask

    function automatic vec_t mk(input bit r, input logic [63:0] o, input logic [31:0] pcr,
                                input logic [31:0] pcw, input logic [4:0] rd, input logic [31:0] wd,
                                input logic [4:0] rs1, input logic [31:0] r1d, input logic [4:0] rs2,
                                input logic [31:0] r2d, input logic tr, input logic hl,
                                input logic ee, input logic [2:0] ec, input logic [63:0] eo,
                                input logic [31:0] er, input logic eh);
        vec_t v;
        v.rst_first = r;
        v.b.order = o; v.b.insn = 32'hA000_0013 ^ o[31:0];
        v.b.pcr = pcr; v.b.pcw = pcw; v.b.rd = rd; v.b.wd = wd;
        v.b.rs1 = rs1; v.b.r1d = r1d; v.b.rs2 = rs2; v.b.r2d = r2d;
        v.b.trap = tr; v.b.halt = hl;
        v.e_err = ee; v.e_code = ec; v.e_order = eo; v.e_ret = er; v.e_halted = eh;
        return v;
    endfunction

    function automatic beat_t gen_beat();
        beat_t b;
        b.order = {32'd0, m_ret};
        b.insn  = $urandom;
        b.pcr   = (m_ret == 0 || m_after_trap) ? ($urandom & 32'hFFFF_FFFC) : m_last_pcw;
        b.pcw   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : b.pcr + 32'd4;
        b.trap  = ($urandom_range(0, 9) == 0);
        if (b.trap) b.pcw = $urandom;
        b.halt  = ($urandom_range(0, 39) == 0);
        b.rd    = 5'($urandom_range(0, 31));
        b.wd    = (b.rd == 0) ? 32'd0 : $urandom;
        b.rs1   = 5'($urandom_range(0, 31));
        b.r1d   = (b.rs1 == 0) ? 32'd0 : (m_wr[b.rs1] ? m_reg[b.rs1] : $urandom);
        b.rs2   = 5'($urandom_range(0, 31));
        b.r2d   = (b.rs2 == 0) ? 32'd0 : (m_wr[b.rs2] ? m_reg[b.rs2] : $urandom);
        if ($urandom_range(0, 11) == 0) begin
            case ($urandom_range(0, 5))
                0: b.order = b.order + 64'd1;
                1: b.pcr = b.pcr ^ 32'h4;
                2: begin b.rd = 0; b.wd = 32'h1; end
                3: b.r1d = b.r1d ^ 32'h1;
                4: b.r2d = b.r2d ^ 32'h8000_0000;
                default: b.pcw = b.pcw | 32'h2;
            endcase
        end
        return b;
    endfunction

    task automatic compare_model(input string tag);
        check({tag, "_err"}, err, m_err);
        check({tag, "_err_code"}, err_code, m_code);
        check({tag, "_err_order"}, err_order, m_eorder);
        check({tag, "_err_insn"}, err_insn, m_einsn);
        check({tag, "_retired"}, retired, m_ret);
        check({tag, "_halted"}, halted, m_halted);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(1, 0, 32'h0,   32'h4,   1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h4,   32'h8,   0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 2, 32'h8,   32'hC,   0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(1, 1, 32'h0,   32'h4,   0, 0,      0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   32'h4,   0, 0,      0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h4,   5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h4,   32'h8,   0, 0, 5, 32'hDEADBEEE, 0, 0, 0, 0, 1, 4, 1, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h4,   0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h10,  32'h14,  0, 32'h1,  0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h4,   0, 0,      0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 32'h4,   32'h8,   0, 0,      0, 0, 0, 0, 0, 0, 1, 7, 1, 1, 1));
        vecs.push_back(mk(1, 0, 32'h0,   32'h100, 3, 32'h55, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h200, 32'h204, 0, 0, 3, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h6,   0, 0,      0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h4,   0, 32'h1,  0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h4,   0, 0,      0, 0, 0, 32'h5, 0, 0, 1, 5, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h4,   0, 0,      0, 32'h1, 0, 32'h1, 0, 0, 1, 4, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h4,   7, 32'hAB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h4,   32'h8,   2, 0,      7, 32'hAB, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 2, 32'h8,   32'hC,   0, 0, 7, 32'hAB, 7, 32'hAC, 0, 0, 1, 5, 2, 2, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h102, 0, 0,      0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h500, 32'h504, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 2, 32'h508, 32'h50C, 0, 0,      0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 0));

        do_reset();
        check("reset_err", err, 1'b0);
        check("reset_err_code", err_code, 3'd0);
        check("reset_err_order", err_order, 64'd0);
        check("reset_err_insn", err_insn, 32'd0);
        check("reset_retired", retired, 32'd0);
        check("reset_halted", halted, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first) do_reset();
            drive_beat(vecs[i].b, 1'b1);
            check($sformatf("vec%0d_err", i), err, vecs[i].e_err);
            check($sformatf("vec%0d_err_code", i), err_code, vecs[i].e_code);
            check($sformatf("vec%0d_err_order", i), err_order, vecs[i].e_order);
            check($sformatf("vec%0d_retired", i), retired, vecs[i].e_ret);
            check($sformatf("vec%0d_halted", i), halted, vecs[i].e_halted);
        end

        // Idle cycles between beats must not disturb anything.
        do_reset();
        begin
            beat_t b;
            b = gen_beat();
            b.order = 0; b.pcr = 0; b.pcw = 32'h4; b.rd = 9; b.wd = 32'h77; b.rs1 = 0; b.r1d = 0;
            b.rs2 = 0; b.r2d = 0; b.trap = 0; b.halt = 0;
            drive_beat(b, 1'b1);
            b.order = 64'd5; b.pcr = 32'h123;
            drive_beat(b, 1'b0);
            drive_beat(b, 1'b0);
            b.order = 1; b.pcr = 32'h4; b.pcw = 32'h8; b.rd = 0; b.wd = 0; b.rs1 = 9; b.r1d = 32'h77;
            drive_beat(b, 1'b1);
            check("idle_gap_err", err, 1'b0);
            check("idle_gap_retired", retired, 32'd2);
        end

        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int k = 0; k < 40; k++) begin
                beat_t b;
                bit vld;
                b = gen_beat();
                vld = ($urandom_range(0, 3) != 0);
                drive_beat(b, vld);
                compare_model($sformatf("rnd%0d_%0d", ep, k));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
